// File: rtl/spi_master_ctrl.sv
// SPI master (CPOL=0, CPHA=0, MSB first) that sequences byte transfers to the
// CPLD SPI slave. Multi-byte frames keep ss_l low between bytes. Optional
// housekeeping pulses with ss_l high: a prime pulse before a frame and a
// flush falling edge after it.
module spi_master_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter bit EN_PRIME = 1'b1,
  parameter bit EN_FLUSH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       last,
  output logic       ready,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ss_l,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRIME_HI,
    S_PRIME_LO,
    S_SEL,
    S_HIGH,
    S_LOW,
    S_GAP,
    S_DESEL,
    S_FLUSH
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    tx_q;
  logic          last_q;
  logic [6:0]    rx_sh_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          ss_l_q;
  logic          sclk_q;
  logic          mosi_q;
  logic          ready_q;
  logic          busy_q;

  logic [7:0]    rx_shift_d;
  logic [7:0]    tx_shift_d;
  logic          tmr_done;

  // Next values of the shift registers and the half-period expiry flag.
  always_comb begin
    rx_shift_d = {rx_sh_q, miso};
    tx_shift_d = {tx_q[6:0], 1'b0};
    tmr_done   = (cnt_q == '0);
  end

  // Transfer sequencer: every timed state lasts CLK_DIV cycles, the divider
  // reloads on each state entry, and all pin outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= RELOAD;
      bit_q      <= '0;
      tx_q       <= '0;
      last_q     <= 1'b0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ss_l_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - ONE;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            tx_q    <= tx_data;
            last_q  <= last;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= RELOAD;
            if (EN_PRIME) begin
              state_q <= S_PRIME_HI;
              sclk_q  <= 1'b1;
            end else begin
              state_q <= S_SEL;
              ss_l_q  <= 1'b0;
              mosi_q  <= tx_data[7];
              bit_q   <= '0;
            end
          end
        end
        S_PRIME_HI: begin
          if (tmr_done) begin
            state_q <= S_PRIME_LO;
            sclk_q  <= 1'b0;
            cnt_q   <= RELOAD;
          end
        end
        S_PRIME_LO: begin
          if (tmr_done) begin
            state_q <= S_SEL;
            ss_l_q  <= 1'b0;
            mosi_q  <= tx_q[7];
            bit_q   <= '0;
            cnt_q   <= RELOAD;
          end
        end
        S_SEL: begin
          if (tmr_done) begin
            state_q <= S_HIGH;
            sclk_q  <= 1'b1;
            cnt_q   <= RELOAD;
          end
        end
        S_HIGH: begin
          if (tmr_done) begin
            rx_sh_q <= rx_shift_d[6:0];
            cnt_q   <= RELOAD;
            if (bit_q == 3'd7) begin
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              if (last_q) begin
                state_q <= S_DESEL;
                ss_l_q  <= 1'b1;
                sclk_q  <= EN_FLUSH;
              end else begin
                state_q <= S_GAP;
                sclk_q  <= 1'b0;
                ready_q <= 1'b1;
              end
            end else begin
              state_q <= S_LOW;
              sclk_q  <= 1'b0;
              mosi_q  <= tx_q[6];
              tx_q    <= tx_shift_d;
              bit_q   <= bit_q + 3'd1;
            end
          end
        end
        S_LOW: begin
          if (tmr_done) begin
            state_q <= S_HIGH;
            sclk_q  <= 1'b1;
            cnt_q   <= RELOAD;
          end
        end
        S_GAP: begin
          if (start) begin
            state_q <= S_SEL;
            tx_q    <= tx_data;
            last_q  <= last;
            mosi_q  <= tx_data[7];
            bit_q   <= '0;
            ready_q <= 1'b0;
            cnt_q   <= RELOAD;
          end
        end
        S_DESEL: begin
          if (tmr_done) begin
            cnt_q <= RELOAD;
            if (EN_FLUSH) begin
              state_q <= S_FLUSH;
              sclk_q  <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              sclk_q  <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (tmr_done) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= RELOAD;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ss_l_q  <= 1'b1;
          sclk_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign ss_l     = ss_l_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three instances with different divider and
// housekeeping settings, a behavioural SPI slave, and a bus monitor that
// reduces the pin activity to bytes, edge counts and event cycles.
module tb_spi_master_ctrl;

  typedef struct {
    int          dut;
    int          nBytes;
    logic [23:0] txBytes;
    logic [23:0] slBytes;
    int          expLatFirst;
    int          expLatNext;
    int          expPrime;
    int          expDeselFalls;
    int          expIdleGap;
  } vecT;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] startV;
  logic [2:0] lastV;
  logic [7:0] txV [3];
  wire  [2:0] misoV;
  wire  [2:0] readyV;
  wire  [2:0] busyV;
  wire  [2:0] rxValidV;
  wire  [2:0] ssV;
  wire  [2:0] sclkV;
  wire  [2:0] mosiV;
  wire  [7:0] rxData0;
  wire  [7:0] rxData1;
  wire  [7:0] rxData2;

  int   act = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic misoBit = 1'b0;

  int         riseCnt, primeCnt, deselFalls, ssFalls, ssRises, mosiBad, rxvLong;
  int         firstRise, idleCyc, bitIdx;
  logic [7:0] mosiSh, slaveCur;
  logic [7:0] mosiQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] slaveQ[$];
  int         rxCyc[$];
  int         spanQ[$];
  logic       pSclk, pSs, pMosi, pRxv, pIdle;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign misoV = {(act == 2) & misoBit, (act == 1) & misoBit, (act == 0) & misoBit};

  spi_master_ctrl #(.CLK_DIV(4), .EN_PRIME(1'b1), .EN_FLUSH(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(startV[0]), .tx_data(txV[0]), .last(lastV[0]),
    .ready(readyV[0]), .busy(busyV[0]), .rx_data(rxData0), .rx_valid(rxValidV[0]),
    .ss_l(ssV[0]), .sclk(sclkV[0]), .mosi(mosiV[0]), .miso(misoV[0]));

  spi_master_ctrl #(.CLK_DIV(1), .EN_PRIME(1'b1), .EN_FLUSH(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(startV[1]), .tx_data(txV[1]), .last(lastV[1]),
    .ready(readyV[1]), .busy(busyV[1]), .rx_data(rxData1), .rx_valid(rxValidV[1]),
    .ss_l(ssV[1]), .sclk(sclkV[1]), .mosi(mosiV[1]), .miso(misoV[1]));

  spi_master_ctrl #(.CLK_DIV(3), .EN_PRIME(1'b0), .EN_FLUSH(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(startV[2]), .tx_data(txV[2]), .last(lastV[2]),
    .ready(readyV[2]), .busy(busyV[2]), .rx_data(rxData2), .rx_valid(rxValidV[2]),
    .ss_l(ssV[2]), .sclk(sclkV[2]), .mosi(mosiV[2]), .miso(misoV[2]));

  function automatic int hOf(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int primeOf(input int d);
    return (d == 2) ? 0 : 1;
  endfunction

  function automatic int flushOf(input int d);
    return (d == 2) ? 0 : 1;
  endfunction

  function automatic logic [7:0] rxDataOf(input int d);
    case (d)
      0:       return rxData0;
      1:       return rxData1;
      default: return rxData2;
    endcase
  endfunction

  // Bus monitor and slave model for the instance selected by act, sampled
  // on the falling clk edge, half a cycle away from the DUT's updates.
  initial begin
    forever begin
      @(negedge clk);
      if (sclkV[act] && !pSclk) begin
        if (!ssV[act]) begin
          riseCnt++;
          mosiSh = {mosiSh[6:0], mosiV[act]};
          if (riseCnt % 8 == 1) firstRise = cyc;
          if (riseCnt % 8 == 0) begin
            mosiQ.push_back(mosiSh);
            spanQ.push_back(cyc - firstRise);
          end
        end else begin
          primeCnt++;
        end
      end
      if (!sclkV[act] && pSclk && ssV[act] && pSs) deselFalls++;
      if (!ssV[act] && sclkV[act] && (mosiV[act] !== pMosi)) mosiBad++;
      if (!ssV[act] && pSs) begin
        ssFalls++;
        slaveCur = (slaveQ.size() > 0) ? slaveQ.pop_front() : 8'h00;
        bitIdx = 0;
      end else if (!ssV[act] && !pSs && pSclk && !sclkV[act]) begin
        bitIdx++;
        if (bitIdx == 8) begin
          bitIdx = 0;
          slaveCur = (slaveQ.size() > 0) ? slaveQ.pop_front() : 8'h00;
        end
      end
      if (ssV[act] && !pSs) ssRises++;
      if (rxValidV[act]) begin
        rxQ.push_back(rxDataOf(act));
        rxCyc.push_back(cyc);
        if (pRxv) rxvLong++;
      end
      if (readyV[act] && !busyV[act] && !pIdle) idleCyc = cyc;
      misoBit = slaveCur[7 - bitIdx];
      pSclk = sclkV[act];
      pSs   = ssV[act];
      pMosi = mosiV[act];
      pRxv  = rxValidV[act];
      pIdle = readyV[act] && !busyV[act];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic clearMon();
    riseCnt = 0; primeCnt = 0; deselFalls = 0; ssFalls = 0; ssRises = 0;
    mosiBad = 0; rxvLong = 0; firstRise = 0; idleCyc = -1; bitIdx = 0;
    mosiSh = 8'h00; slaveCur = 8'h00;
    mosiQ.delete(); rxQ.delete(); slaveQ.delete(); rxCyc.delete(); spanQ.delete();
    pSclk = 1'b0; pSs = 1'b1; pMosi = 1'b0; pRxv = 1'b0; pIdle = 1'b1;
  endtask

  task automatic waitReady(input int d);
    int n = 0;
    while (!readyV[d] && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    if (!readyV[d]) checkOutput("readyTimeout", 0, 1);
  endtask

  task automatic waitRx(input int count);
    int n = 0;
    while (rxQ.size() < count && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    if (rxQ.size() < count) checkOutput("rxTimeout", rxQ.size(), count);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (idleCyc < 0 && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    if (idleCyc < 0) checkOutput("idleTimeout", 0, 1);
  endtask

  task automatic startByte(input int d, input logic [7:0] tx, input logic lst, output int acc);
    waitReady(d);
    startV[d] = 1'b1;
    txV[d]    = tx;
    lastV[d]  = lst;
    acc       = cyc + 1;
    @(negedge clk); #1;
    startV[d] = 1'b0;
    txV[d]    = ~tx;
    lastV[d]  = ~lst;
  endtask

  task automatic applyStimulus(input vecT v);
    int d;
    int acc;
    d = v.dut;
    act = d;
    clearMon();
    for (int k = 0; k < v.nBytes; k++) slaveQ.push_back(v.slBytes[8*k +: 8]);
    for (int k = 0; k < v.nBytes; k++) begin
      startByte(d, v.txBytes[8*k +: 8], (k == v.nBytes - 1), acc);
      waitRx(k + 1);
      if (rxCyc.size() > k)
        checkOutput("latency", rxCyc[k] - acc, (k == 0) ? v.expLatFirst : v.expLatNext);
    end
    waitIdle();
    if (idleCyc >= 0 && rxCyc.size() > 0)
      checkOutput("idleGap", idleCyc - rxCyc[rxCyc.size() - 1], v.expIdleGap);
    checkOutput("rxCount", rxQ.size(), v.nBytes);
    checkOutput("mosiByteCount", mosiQ.size(), v.nBytes);
    for (int k = 0; k < v.nBytes; k++) begin
      if (rxQ.size() > k) checkOutput("rxData", rxQ[k], v.slBytes[8*k +: 8]);
      if (mosiQ.size() > k) checkOutput("mosiByte", mosiQ[k], v.txBytes[8*k +: 8]);
      if (spanQ.size() > k) checkOutput("edgeSpan", spanQ[k], 14 * hOf(d));
    end
    checkOutput("risingEdges", riseCnt, 8 * v.nBytes);
    checkOutput("primePulses", primeCnt, v.expPrime);
    checkOutput("deselFalls", deselFalls, v.expDeselFalls);
    checkOutput("ssFalls", ssFalls, 1);
    checkOutput("ssRises", ssRises, 1);
    checkOutput("mosiUnstable", mosiBad, 0);
    checkOutput("rxValidWidth", rxvLong, 0);
  endtask

  // Reference expectations derived from the timing rules of the block.
  function automatic vecT modelVec(input int d, input int n, input logic [23:0] tx, input logic [23:0] sl);
    vecT v;
    v.dut           = d;
    v.nBytes        = n;
    v.txBytes       = tx;
    v.slBytes       = sl;
    v.expLatFirst   = 16 * hOf(d) + (primeOf(d) != 0 ? 2 * hOf(d) : 0);
    v.expLatNext    = 16 * hOf(d);
    v.expPrime      = primeOf(d);
    v.expDeselFalls = primeOf(d) + flushOf(d);
    v.expIdleGap    = (flushOf(d) != 0) ? 2 * hOf(d) : hOf(d);
    return v;
  endfunction

  initial begin
    vecT vecs [5];
    vecT rv;
    int  acc;
    int  n;

    vecs[0] = '{0, 1, 24'h00004F, 24'h0000B7, 72, 64, 1, 2, 8};
    vecs[1] = '{0, 2, 24'h003CA5, 24'h00C35A, 72, 64, 1, 2, 8};
    vecs[2] = '{1, 1, 24'h000096, 24'h000069, 18, 16, 1, 2, 2};
    vecs[3] = '{2, 1, 24'h0000E1, 24'h00001E, 48, 48, 0, 0, 3};
    vecs[4] = '{2, 3, 24'h81FF00, 24'h7E00FF, 48, 48, 0, 0, 3};

    rst = 1'b1;
    startV = '0;
    lastV = '0;
    for (int i = 0; i < 3; i++) txV[i] = 8'h00;
    clearMon();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetSsL", ssV, 3'b111);
    checkOutput("resetSclk", sclkV, 3'b000);
    checkOutput("resetMosi", mosiV, 3'b000);
    checkOutput("resetReady", readyV, 3'b111);
    checkOutput("resetBusy", busyV, 3'b000);
    checkOutput("resetRxValid", rxValidV, 3'b000);
    checkOutput("resetRxData", rxData0, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %0d on instance %0d", i, vecs[i].dut);
      applyStimulus(vecs[i]);
    end

    $display("[TB] start pulses while shifting must be ignored");
    act = 0;
    clearMon();
    slaveQ.push_back(8'h0F);
    startByte(0, 8'hC3, 1'b1, acc);
    n = 0;
    while (riseCnt < 2 && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (riseCnt < 2) checkOutput("riseTimeout", riseCnt, 2);
    startV[0] = 1'b1;
    txV[0] = 8'hFF;
    lastV[0] = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    startV[0] = 1'b0;
    waitRx(1);
    waitIdle();
    if (mosiQ.size() > 0) checkOutput("ignoredStartMosi", mosiQ[0], 8'hC3);
    if (rxQ.size() > 0) checkOutput("ignoredStartRx", rxQ[0], 8'h0F);
    repeat (60) @(negedge clk);
    #1;
    checkOutput("ignoredStartRxCount", rxQ.size(), 1);
    checkOutput("ignoredStartEdges", riseCnt, 8);
    checkOutput("ignoredStartSsFalls", ssFalls, 1);

    $display("[TB] reset after the third rising edge");
    clearMon();
    slaveQ.push_back(8'h00);
    startByte(0, 8'hFF, 1'b1, acc);
    n = 0;
    while (riseCnt < 3 && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (riseCnt < 3) checkOutput("riseTimeout", riseCnt, 3);
    checkOutput("preResetMosi", mosiV[0], 1);
    rst = 1'b1;
    @(negedge clk); #1;
    checkOutput("abortSsL", ssV[0], 1);
    checkOutput("abortSclk", sclkV[0], 0);
    checkOutput("abortMosi", mosiV[0], 0);
    checkOutput("abortReady", readyV[0], 1);
    checkOutput("abortBusy", busyV[0], 0);
    checkOutput("abortRxData", rxData0, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    applyStimulus(vecs[0]);

    $display("[TB] randomized frames");
    for (int i = 0; i < 12; i++) begin
      rv = modelVec($urandom_range(0, 2), $urandom_range(1, 3), 24'($urandom), 24'($urandom));
      applyStimulus(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
